// File: rtl/edge_frame_packer.sv
// Binarizes the canny pixel stream, packs 8 pixels per byte into a FIFO and
// sends one framed packet per image (A5 5A payload xor-checksum) over valid/ready.
module edge_frame_packer #(
  parameter int IMG_WIDTH  = 80,
  parameter int IMG_HEIGHT = 120,
  parameter int BIN_TH     = 128,
  parameter int FIFO_AW    = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       canny_de,
  input  logic [7:0] canny_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_sent,
  output logic       overflow
);

  localparam int NPIX          = IMG_WIDTH * IMG_HEIGHT;
  localparam int PAYLOAD_BYTES = NPIX / 8;
  localparam int PW            = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int BW            = $clog2(PAYLOAD_BYTES + 1);
  localparam int DEPTH         = 1 << FIFO_AW;
  localparam logic [8:0]    TH9      = 9'(BIN_TH);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(PAYLOAD_BYTES - 1);

  if ((NPIX % 8) != 0) begin : g_size_check
    $error("edge_frame_packer: IMG_WIDTH*IMG_HEIGHT must be a multiple of 8");
  end

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAY, CSUM} state_t;

  state_t state_q, state_d;

  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [PW-1:0] pix_cnt;
  logic          push_vld;
  logic [7:0]    push_dat;
  logic          pix_bit;
  logic          frame_start;
  logic          pending;
  logic          take;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             pop, push_ok;
  logic [7:0]       head;

  logic [7:0]    csum;
  logic [BW-1:0] byte_cnt;

  assign pix_bit     = ({1'b0, canny_data} >= TH9);
  assign frame_start = canny_de && (pix_cnt == '0);
  assign take        = (state_q == IDLE) && pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if (canny_de) begin
        shreg   <= {shreg[6:0], pix_bit};
        bit_cnt <= bit_cnt + 3'd1;
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PW'(1);
        if (bit_cnt == 3'd7) begin
          push_vld <= 1'b1;
          push_dat <= {shreg[6:0], pix_bit};
        end
      end
    end
  end

  // Show-ahead FIFO; a pop in the same cycle frees the slot for a push when full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign push_ok    = push_vld && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A frame start while one is still waiting would misalign the packet stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending && !take) || frame_start;
      if ((push_vld && !push_ok) || (frame_start && pending && !take))
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      csum     <= '0;
      byte_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        csum     <= '0;
        byte_cnt <= '0;
      end else if (pop) begin
        csum     <= csum ^ head;
        byte_cnt <= byte_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    frame_sent = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) state_d = HDR0;
      end
      HDR0: begin
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        if (tx_ready) state_d = HDR1;
      end
      HDR1: begin
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        if (tx_ready) state_d = PAY;
      end
      PAY: begin
        tx_data  = fifo_empty ? 8'h00 : head;
        tx_valid = !fifo_empty;
        if (!fifo_empty && tx_ready) begin
          pop = 1'b1;
          if (byte_cnt == BYTE_LAST) state_d = CSUM;
        end
      end
      CSUM: begin
        tx_data  = csum;
        tx_valid = 1'b1;
        if (tx_ready) begin
          frame_sent = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_frame_packer.sv
// Directed bench for edge_frame_packer: full frames at default size plus a
// small-FIFO instance for the overflow boundary.
module tb_edge_frame_packer;

  localparam int NPIX = 80 * 120;
  localparam int PAY  = NPIX / 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       canny_de = 1'b0;
  logic [7:0] canny_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, frame_sent, overflow;

  logic       s_de = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready = 1'b0;
  logic [7:0] s_tx_data;
  logic       s_tx_valid, s_frame_sent, s_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int rmode   = 0;
  int fs_cnt  = 0;
  int fs_idx  = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data  = 8'h00;
  logic [7:0] rx_q [$];
  logic [7:0] pix [NPIX];

  always #5 clk = ~clk;

  edge_frame_packer dut (
    .clk(clk), .reset(reset), .canny_de(canny_de), .canny_data(canny_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_sent(frame_sent), .overflow(overflow)
  );

  edge_frame_packer #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .BIN_TH(128), .FIFO_AW(4)) dut_s (
    .clk(clk), .reset(reset), .canny_de(s_de), .canny_data(s_data),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_ready),
    .frame_sent(s_frame_sent), .overflow(s_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, held_data);
      end
      stall_prev = tx_valid && !tx_ready;
      held_data  = tx_data;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (frame_sent) begin
        fs_cnt++;
        fs_idx = rx_q.size();
      end
    end
  end

  function automatic logic [7:0] gen(int mode, int i);
    case (mode)
      0:       return 8'hFF;
      1:       return (i % 2 == 0) ? 8'hFF : 8'h00;
      2:       return (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : 8'h00;
      default: return 8'(i * 37);
    endcase
  endfunction

  task automatic drive_pixels(input int mode, input int npix, input bit check_lat, input int stop_ready_at);
    for (int i = 0; i < NPIX; i++) pix[i] = gen(mode, i);
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      if (check_lat && i == 1) chk("lat_n1_valid", tx_valid, 0);
      if (check_lat && i == 2) begin
        chk("lat_n2_valid", tx_valid, 1);
        chk("lat_n2_hdr", tx_data, 8'hA5);
      end
      if (i == stop_ready_at) rmode = 0;
      canny_de   = 1'b1;
      canny_data = pix[i];
    end
    @(posedge clk); #1;
    canny_de = 1'b0;
  endtask

  task automatic run_frame(input string name, input int mode, input int ready_mode,
                           input bit check_lat, input logic [7:0] hand_b0,
                           input bit use_hand_cs, input logic [7:0] hand_cs);
    logic [7:0] eb;
    logic [7:0] ecs;
    int bad;
    int cyc;
    rx_q.delete();
    fs_cnt = 0;
    rmode  = ready_mode;
    drive_pixels(mode, NPIX, check_lat, -1);
    cyc = 0;
    while (fs_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20000) chk({name, "_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_len"}, rx_q.size(), PAY + 3);
    chk({name, "_fs_cnt"}, fs_cnt, 1);
    chk({name, "_fs_idx"}, fs_idx, PAY + 3);
    chk({name, "_ovf"}, overflow, 0);
    if (rx_q.size() == PAY + 3) begin
      chk({name, "_hdr0"}, rx_q[0], 8'hA5);
      chk({name, "_hdr1"}, rx_q[1], 8'h5A);
      chk({name, "_b0_hand"}, rx_q[2], hand_b0);
      bad = 0;
      ecs = 8'h00;
      for (int j = 0; j < PAY; j++) begin
        eb = 8'h00;
        for (int k = 0; k < 8; k++) eb = {eb[6:0], (pix[j*8+k] >= 8'd128)};
        ecs ^= eb;
        if (rx_q[j+2] !== eb) bad++;
      end
      chk({name, "_payload_bad"}, bad, 0);
      chk({name, "_csum"}, rx_q[PAY+2], ecs);
      if (use_hand_cs) chk({name, "_csum_hand"}, rx_q[PAY+2], hand_cs);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_fs", frame_sent, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid", tx_valid, 0);

    run_frame("all_ff", 0, 1, 1'b1, 8'hFF, 1'b1, 8'h00);
    run_frame("alt", 1, 1, 1'b0, 8'hAA, 1'b1, 8'h00);
    run_frame("thresh", 2, 1, 1'b0, 8'h40, 1'b1, 8'h40);
    run_frame("rand_rdy", 0, 2, 1'b0, 8'hFF, 1'b1, 8'h00);

    // partial frame: payload in flight, FIFO backed up, half-packed byte
    rx_q.delete();
    rmode = 1;
    drive_pixels(0, 2003, 1'b0, 1000);
    chk("mid_state_valid", tx_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid", tx_valid, 0);
    run_frame("after_rst", 3, 1, 1'b1, 8'h0E, 1'b0, 8'h00);

    // small FIFO (16 bytes), transmitter never ready
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      s_de = 1'b1; s_data = 8'hFF;
    end
    @(posedge clk); #1;
    s_de = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("s16_ovf", s_overflow, 0);
    chk("s16_valid", s_tx_valid, 1);
    chk("s16_hdr", s_tx_data, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      s_de = 1'b1; s_data = 8'hFF;
    end
    @(posedge clk); #1;
    s_de = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("s17_ovf", s_overflow, 1);
    chk("s17_valid", s_tx_valid, 1);
    chk("s17_hdr", s_tx_data, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
